pipe_out_block_arbiter: RTL and testbench
=========================================

Name: pipe_out_block_arbiter

Overview:
Shares one block-throttled PipeOut endpoint (addr 0xA0 class) between N_SRC first-word-fall-through source FIFOs on okClk. Arbitration is round-robin at block granularity: a source is granted only when it holds a full block's payload, and the grant is locked until that block completes. Each block starts with a header word carrying the source id and a per-source sequence number, so host software can demultiplex the streams. Sits between the source FIFOs and the okBTPipeOut ep_read/ep_blockstrobe/ep_datain/ep_ready ports.

Parameters:
N_SRC, 4, number of requesting sources (1..8)
BLOCK_WORDS, 256, 32-bit words per pipe block, header included (>=2)
CNT_W, 10, width of each source fill-count input

Ports:
clk  in  1  okClk; all logic rising-edge
reset  in  1  asynchronous, active-high; returns block to IDLE
src_count  in  N_SRC*CNT_W  per-source FIFO word count; slice i = source i
src_data  in  N_SRC*32  per-source FWFT head word
src_rd  out  N_SRC  one-hot pop strobe, one cycle per word
src_enable  in  N_SRC  per-source grant mask (from a WireIn)
pipe_out_read  in  1  ep_read from okBTPipeOut
pipe_out_blockstrobe  in  1  ep_blockstrobe from okBTPipeOut
pipe_out_data  out  32  ep_datain, registered
pipe_out_ready  out  1  ep_ready
grant_id  out  3  currently or last granted source
busy  out  1  high in ARMED or XFER
blocks_sent  out  32  completed-block counter, wraps
protocol_error  out  1  sticky error flag

Behaviour:
- Reset values: src_rd=0, pipe_out_data=0, pipe_out_ready=0, grant_id=0, busy=0, blocks_sent=0, protocol_error=0, all seq counters=0, rr pointer=0, state=IDLE.
- Eligibility: source i is eligible when src_enable[i]=1 and src_count[i] >= BLOCK_WORDS-1.
- IDLE: scan starts at rr pointer, wrapping modulo N_SRC; the first eligible source is latched into grant_id, next state ARMED. If nothing is eligible, stay in IDLE. Scan is combinational, so the transition happens in the same cycle.
- ARMED: pipe_out_ready=1. On pipe_out_blockstrobe go to XFER with word index=0 and drop ready on the next cycle. Grant is fixed from here on. src_enable or src_count changes do not revoke it.
- XFER: each pipe_out_read cycle advances the word index.
  - Index 0: pipe_out_data <= {8'hA5, 5'b0, grant_id, seq[grant_id]} on the following edge (1-cycle latency); no pop.
  - Index 1..BLOCK_WORDS-1: pipe_out_data <= src_data[grant_id], with src_rd[grant_id]=1 in the read cycle (combinational from pipe_out_read and state).
  - After the read at index BLOCK_WORDS-1:
    - seq[grant_id] increments, wrapping 0xFFFF->0.
    - blocks_sent increments.
    - rr pointer becomes grant_id+1 mod N_SRC.
    - state returns to IDLE.
- Throughput: gaps in pipe_out_read within a block are legal; the index holds and src_rd stays 0.
- Next block: ready re-asserts one cycle after IDLE at the earliest, which gives a minimum 1-cycle bubble between blocks.
- protocol_error set (sticky until reset) on any of:
  - pipe_out_read while in IDLE or ARMED; data driven 0, no pop.
  - pipe_out_blockstrobe while in XFER; ignored otherwise.
  - A pop issued while src_count[grant_id]==0. This is an underflow and must never happen if eligibility holds; checked by assertion.
- Reset mid-block: immediate abort. Partially popped payload is lost and seq is not incremented (it is cleared anyway). The host detects the abort by header discontinuity.
- N_SRC=1 degenerates to a block framer; the rr pointer stays 0.

Decomposition:
- Package pipe_arb_pkg:
  - state enum {IDLE, ARMED, XFER}
  - HDR_MAGIC=8'hA5
  - header field offsets
  - function make_header(id, seq)
- One sub-module rr_pick: parameterised round-robin first-eligible finder; inputs are the eligible mask and the pointer, outputs are the index and a found flag; purely combinational.
- The FSM, counters, seq array and output register stay in pipe_out_block_arbiter.

Test Plan:
- Single source: src0 count=255, enable=0001, BLOCK_WORDS=256, host reads 256 -> word0=0xA5000000, words1..255 match src0 data, 255 src_rd[0] pulses, blocks_sent=1, seq0=1.
- Round-robin: all four sources full, enable=1111, host reads 4 blocks -> header ids 0,1,2,3 in order, each seq=0; 5th block id=0 with seq=1.
- Ineligible skip: src1 count=254, others full, pointer=1 -> grant=2. src1 reaching 255 later is served after 3, 0.
- Mid-block mask change: src_enable[2] cleared during the XFER of source 2 -> block completes with all 255 pops; source 2 is not granted next.
- Protocol errors:
  - pipe_out_read in IDLE -> protocol_error=1, data 0, no src_rd.
  - A second blockstrobe during XFER -> flag stays set.
- Async reset at word 100 of a block -> all outputs at reset values without waiting for a clock edge. The next block header seq=0 and is granted from pointer 0.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_arb_pkg
//  Purpose  : Shared state encoding, header layout and header builder for
//             the block-granular PipeOut arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARMED = 2'd1;
    localparam state_t ST_XFER  = 2'd2;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header word layout: [31:24] magic, [23:19] zero, [18:16] id, [15:0] seq
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_ID_LSB    = 16;
    localparam int HDR_SEQ_LSB   = 0;

    function automatic logic [31:0] make_header(input logic [2:0]  id,
                                                input logic [15:0] seq);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        h[HDR_ID_LSB    +: 3] = id;
        h[HDR_SEQ_LSB   +: 16] = seq;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_out_block_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin finder. Returns the first set bit of
//             i_elig at or after i_ptr, wrapping modulo N.
//  Ports    : i_elig  - eligible mask
//             i_ptr   - scan start index
//             o_idx   - first eligible index (0 when none)
//             o_found - at least one eligible source
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p,
                                               input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && i_elig[wrap_add(i_ptr, k)]) begin
                o_idx   = wrap_add(i_ptr, k);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_out_block_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_out_block_arbiter
//  Purpose  : Shares one block-throttled PipeOut between N_SRC FWFT FIFOs.
//             Round-robin at block granularity; each block is a header word
//             (magic, source id, per-source sequence) plus BLOCK_WORDS-1
//             payload words popped from the granted source.
//  Ports    : clk/reset            - okClk, async active-high reset
//             src_count/data/rd    - per-source FIFO fill, head word, pop
//             src_enable           - per-source grant mask
//             pipe_out_*           - okBTPipeOut endpoint side
//             grant_id, busy       - status of current/last grant
//             blocks_sent          - completed-block counter (wraps)
//             protocol_error       - sticky host/FIFO misuse flag
//  Revision : 1.0  initial release
// ============================================================================
module pipe_out_block_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*CNT_W-1:0] src_count,
    input  logic [N_SRC*32-1:0]    src_data,
    output logic [N_SRC-1:0]       src_rd,
    input  logic [N_SRC-1:0]       src_enable,
    input  logic                   pipe_out_read,
    input  logic                   pipe_out_blockstrobe,
    output logic [31:0]            pipe_out_data,
    output logic                   pipe_out_ready,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic [31:0]            blocks_sent,
    output logic                   protocol_error
);

    localparam int GW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int NSEQ = 1 << GW;
    localparam int IXW  = $clog2(BLOCK_WORDS);
    localparam logic [IXW-1:0] LAST_IDX = IXW'(BLOCK_WORDS - 1);

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;
    logic [IXW-1:0]  r_idx;
    logic [31:0]     r_data;
    logic [31:0]     r_blocks;
    logic            r_err;
    logic [15:0]     r_seq [NSEQ];

    logic [N_SRC-1:0] w_elig;
    logic [GW-1:0]    w_pick;
    logic             w_found;
    logic [CNT_W-1:0] w_grant_cnt;
    logic [31:0]      w_grant_data;
    logic             w_pop;
    logic [N_SRC-1:0] w_rd;
    logic [GW-1:0]    w_ptr_next;

    // A source needs a whole block's payload (header excluded) before grant.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_elig
        assign w_elig[gi] = src_enable[gi] &&
            (32'(src_count[gi*CNT_W +: CNT_W]) >= 32'(BLOCK_WORDS - 1));
    end

    rr_pick #(
        .N  (N_SRC),
        .IW (GW)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_grant_cnt  = src_count[r_grant*CNT_W +: CNT_W];
    assign w_grant_data = src_data[r_grant*32 +: 32];

    // Word 0 is the header, so no pop on the first read of a block.
    assign w_pop = (r_state == ST_XFER) && pipe_out_read && (r_idx != '0);

    always_comb begin
        w_rd = '0;
        if (w_pop) w_rd[r_grant] = 1'b1;
    end

    assign w_ptr_next = (int'(r_grant) == N_SRC - 1) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_blocks <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < NSEQ; i++) r_seq[i] <= '0;
        end else begin
            // Reads outside a block return zero and flag the host.
            if (pipe_out_read && (r_state != ST_XFER)) begin
                r_err  <= 1'b1;
                r_data <= '0;
            end
            if (pipe_out_blockstrobe && (r_state == ST_XFER)) r_err <= 1'b1;
            if (w_pop && (w_grant_cnt == '0)) r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (pipe_out_blockstrobe) begin
                        r_state <= ST_XFER;
                        r_idx   <= '0;
                    end
                end
                ST_XFER: begin
                    if (pipe_out_read) begin
                        if (r_idx == '0)
                            r_data <= make_header(3'(r_grant), r_seq[r_grant]);
                        else
                            r_data <= w_grant_data;
                        if (r_idx == LAST_IDX) begin
                            r_seq[r_grant] <= r_seq[r_grant] + 16'd1;
                            r_blocks       <= r_blocks + 32'd1;
                            r_ptr          <= w_ptr_next;
                            r_idx          <= '0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(w_pop && (w_grant_cnt == '0)));

    assign src_rd         = w_rd;
    assign pipe_out_data  = r_data;
    assign pipe_out_ready = (r_state == ST_ARMED);
    assign grant_id       = 3'(r_grant);
    assign busy           = (r_state != ST_IDLE);
    assign blocks_sent    = r_blocks;
    assign protocol_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_out_block_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_out_block_arbiter
//  Purpose  : Directed self-checking bench for pipe_out_block_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_out_block_arbiter;

    localparam int N_SRC = 4;
    localparam int BW    = 256;
    localparam int CNT_W = 10;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_SRC*CNT_W-1:0] src_count;
    logic [N_SRC*32-1:0]    src_data;
    logic [N_SRC-1:0]       src_rd;
    logic [N_SRC-1:0]       src_enable;
    logic                   pipe_out_read;
    logic                   pipe_out_blockstrobe;
    logic [31:0]            pipe_out_data;
    logic                   pipe_out_ready;
    logic [2:0]             grant_id;
    logic                   busy;
    logic [31:0]            blocks_sent;
    logic                   protocol_error;

    int checks = 0;
    int errors = 0;

    logic [15:0] pops [N_SRC];

    pipe_out_block_arbiter #(
        .N_SRC       (N_SRC),
        .BLOCK_WORDS (BW),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .src_count            (src_count),
        .src_data             (src_data),
        .src_rd               (src_rd),
        .src_enable           (src_enable),
        .pipe_out_read        (pipe_out_read),
        .pipe_out_blockstrobe (pipe_out_blockstrobe),
        .pipe_out_data        (pipe_out_data),
        .pipe_out_ready       (pipe_out_ready),
        .grant_id             (grant_id),
        .busy                 (busy),
        .blocks_sent          (blocks_sent),
        .protocol_error       (protocol_error)
    );

    always #5 clk = ~clk;

    // FWFT source model: head word encodes source and pop ordinal.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) pops[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++)
                if (src_rd[i]) pops[i] <= pops[i] + 16'd1;
        end
    end

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N_SRC; i++)
            src_data[i*32 +: 32] = {4'hD, 4'(i), 8'h00, pops[i]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst_src_rd", 32'(src_rd), 0);
        chk("rst_data", pipe_out_data, 0);
        chk("rst_ready", 32'(pipe_out_ready), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_blocks", blocks_sent, 0);
        chk("rst_err", 32'(protocol_error), 0);
    endtask

    task automatic set_count(input int i, input int v);
        src_count[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One host block transfer with optional read gaps, mid-block mask clear,
    // stray blockstrobe, or async reset at a given word index (-1 = none).
    task automatic do_block(input int id, input int seq, input bit gaps,
                            input int clr_at, input int strobe_at, input int rst_at);
        int               w;
        int               bad;
        int               npop;
        int               extra;
        logic [15:0]      base;
        logic [31:0]      exp;
        logic [N_SRC-1:0] exp_rd;
        w = 0;
        while (!pipe_out_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!pipe_out_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        chk("grant_id", 32'(grant_id), 32'(id));
        pipe_out_blockstrobe = 1'b1;
        @(negedge clk);
        pipe_out_blockstrobe = 1'b0;
        chk("ready_drop", 32'(pipe_out_ready), 0);
        base  = pops[id];
        bad   = 0;
        npop  = 0;
        extra = 0;
        for (int k = 0; k < BW; k++) begin
            if (gaps && (k % 50 == 7)) begin
                pipe_out_read = 1'b0;
                #1;
                if (src_rd != '0) extra++;
                @(negedge clk);
            end
            pipe_out_read = 1'b1;
            if (k == strobe_at) pipe_out_blockstrobe = 1'b1;
            if (k == clr_at) src_enable[id] = 1'b0;
            #1;
            exp_rd = (k == 0) ? '0 : (N_SRC'(1) << id);
            if (src_rd !== exp_rd) extra++;
            if (src_rd[id]) npop++;
            if (k == rst_at) begin
                reset = 1'b1;
                pipe_out_read = 1'b0;
                #1;
                chk_rst();
                return;
            end
            @(negedge clk);
            pipe_out_blockstrobe = 1'b0;
            if (k == 0) begin
                chk("header", pipe_out_data, {8'hA5, 5'b0, 3'(id), 16'(seq)});
            end else begin
                exp = {4'hD, 4'(id), 8'h00, 16'(base + 16'(k - 1))};
                if (pipe_out_data !== exp) bad++;
            end
        end
        pipe_out_read = 1'b0;
        chk("payload_bad_words", 32'(bad), 0);
        chk("pop_count", 32'(npop), 32'(BW - 1));
        chk("rd_strobe_errs", 32'(extra), 0);
        chk("bubble_ready", 32'(pipe_out_ready), 0);
    endtask

    initial begin
        reset = 1'b1;
        pipe_out_read = 1'b0;
        pipe_out_blockstrobe = 1'b0;
        src_enable = '0;
        src_count = '0;
        @(negedge clk);
        @(negedge clk);
        chk_rst();
        reset = 1'b0;

        // Single source framing
        set_count(0, 255);
        src_enable = 4'b0001;
        do_block(0, 0, 1'b0, -1, -1, -1);
        chk("single_blocks", blocks_sent, 1);
        chk("single_err", 32'(protocol_error), 0);
        do_block(0, 1, 1'b0, -1, -1, -1);
        chk("single_blocks2", blocks_sent, 2);

        // Round-robin over four full sources, with read gaps
        do_reset();
        for (int i = 0; i < N_SRC; i++) set_count(i, 255);
        src_enable = 4'b1111;
        for (int b = 0; b < 4; b++) do_block(b, 0, 1'b1, -1, -1, -1);
        do_block(0, 1, 1'b1, -1, -1, -1);
        chk("rr_blocks", blocks_sent, 5);

        // Ineligible source skipped, served later in turn
        do_reset();
        set_count(1, 254);
        do_block(0, 0, 1'b0, -1, -1, -1);
        do_block(2, 0, 1'b0, -1, -1, -1);
        set_count(1, 255);
        do_block(3, 0, 1'b0, -1, -1, -1);
        do_block(0, 1, 1'b0, -1, -1, -1);
        do_block(1, 0, 1'b0, -1, -1, -1);

        // Mask cleared mid-block: block completes, source 2 then skipped
        do_reset();
        src_enable = 4'b1111;
        do_block(0, 0, 1'b0, -1, -1, -1);
        do_block(1, 0, 1'b0, -1, -1, -1);
        do_block(2, 0, 1'b0, 100, -1, -1);
        do_block(3, 0, 1'b0, -1, -1, -1);
        do_block(0, 1, 1'b0, -1, -1, -1);
        do_block(1, 1, 1'b0, -1, -1, -1);
        do_block(3, 1, 1'b0, -1, -1, -1);

        // Read in IDLE
        src_enable = '0;
        chk("pre_idle_err", 32'(protocol_error), 0);
        pipe_out_read = 1'b1;
        #1;
        chk("idle_read_no_pop", 32'(src_rd), 0);
        @(negedge clk);
        pipe_out_read = 1'b0;
        chk("idle_read_err", 32'(protocol_error), 1);
        chk("idle_read_data", pipe_out_data, 0);

        // Stray blockstrobe during transfer
        do_reset();
        chk("strobe_pre_err", 32'(protocol_error), 0);
        src_enable = 4'b0001;
        do_block(0, 0, 1'b0, -1, 10, -1);
        src_enable = '0;
        repeat (3) @(negedge clk);
        chk("strobe_err_sticky", 32'(protocol_error), 1);

        // Async reset mid-block, then restart from pointer 0 with seq 0
        do_reset();
        src_enable = 4'b1111;
        do_block(0, 0, 1'b0, -1, -1, -1);
        do_block(1, 0, 1'b0, -1, -1, 100);
        @(negedge clk);
        reset = 1'b0;
        do_block(0, 0, 1'b0, -1, -1, -1);
        chk("post_abort_blocks", blocks_sent, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
